// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg
//   Shared constants and types for the CPU bus interconnect: system register
//   addresses, echo RAM window, OAM base, DMA transfer length and the DMA
//   state encoding. Also provides the echo RAM address remap helper.
package gb_bus_pkg;

    localparam logic [15:0] ADDR_IE       = 16'hFFFF;
    localparam logic [15:0] ADDR_IF       = 16'hFF0F;
    localparam logic [15:0] ADDR_BOOT_OFF = 16'hFF50;
    localparam logic [15:0] ADDR_DMA      = 16'hFF46;

    localparam logic [15:0] ECHO_LO  = 16'hE000;
    localparam logic [15:0] ECHO_HI  = 16'hFDFF;
    localparam logic [15:0] ECHO_OFS = 16'h2000;

    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam int          DMA_LEN  = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RD    = 2'd2,
        WR    = 2'd3
    } dma_state_t;

    // Echo RAM (E000-FDFF) aliases work RAM at C000-DDFF. FE00 and above
    // are real OAM/IO space and must never be remapped.
    function automatic logic [15:0] echo_remap(input logic [15:0] addr,
                                               input logic        enable);
        if (enable && (addr >= ECHO_LO) && (addr <= ECHO_HI))
            return addr - ECHO_OFS;
        else
            return addr;
    endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// gb_oam_dma
//   OAM DMA engine: copies DMA_LEN bytes from {src,00}..{src,9F} to
//   FE00..FE9F, alternating one read cycle and one write cycle per byte.
//   Ports:
//     clk, reset_n   clock, synchronous active-low reset (aborts a transfer)
//     start          one-cycle request, accepted only in IDLE
//     src_in         source high byte captured on start
//     rd_data        slave read data for the current read address
//     addr           bus address while busy (read source or OAM target)
//     wr             write strobe (WR state)
//     wr_data        byte latched during the preceding RD state
//     src            last accepted source high byte (read back at FF46)
//     state          current FSM state (debug / busy decode)
module gb_oam_dma
    import gb_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  src_in,
    input  logic [7:0]  rd_data,
    output logic [15:0] addr,
    output logic        wr,
    output logic [7:0]  wr_data,
    output logic [7:0]  src,
    output dma_state_t  state
);

    logic [7:0] idx;
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= 8'd0;
            data_q <= 8'd0;
            src    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src   <= src_in;
                        idx   <= 8'd0;
                        state <= START;
                    end
                end
                START: state <= RD;
                RD: begin
                    data_q <= rd_data;
                    state  <= WR;
                end
                WR: begin
                    if (idx == 8'(DMA_LEN - 1)) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free
    // relative to the state register.
    assign addr    = (state == WR) ? {OAM_BASE[15:8], idx} : {src, idx};
    assign wr      = (state == WR);
    assign wr_data = data_q;

endmodule

// File: rtl/gb_bus_ctrl.sv
// gb_bus_ctrl
//   CPU bus interconnect. Decodes the CPU address onto NUM_SLAVES slaves
//   (lowest active index wins), remaps echo RAM, and owns the IE, IF and
//   boot-ROM-disable registers. Optional OAM DMA is built when the macro
//   GB_BUS_OAM_DMA_EN is defined; otherwise FF46 reads FF and cpu_stall is 0.
//   Ports:
//     clk, reset_n                   clock, synchronous active-low reset
//     cpu_addr/cpu_data_w/cpu_do_write   CPU bus cycle
//     cpu_data_r                     combinational read data
//     cpu_stall                      CPU holds its cycle while high
//     slv_addr/slv_data_w/slv_do_write   shared slave bus
//     slv_data_r/slv_active          per-slave read data and address claim
//     irq_req/irq_ack/irq_ack_idx    interrupt set pulses and acknowledge
//     irq_pending                    registered IE & IF
//     bootrom_enabled                boot ROM overlay flag
//   Bus contract: there is no ready handshake on the CPU side; a CPU cycle
//   presented while cpu_stall is high is not performed (writes are dropped,
//   reads return FF) and the CPU is expected to hold it.
module gb_bus_ctrl
    import gb_bus_pkg::*;
#(
    parameter int NUM_SLAVES  = 6,
    parameter int INT_BITS    = 5,
    parameter int ECHO_MIRROR = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [15:0]             cpu_addr,
    input  logic [7:0]              cpu_data_w,
    input  logic                    cpu_do_write,
    output logic [7:0]              cpu_data_r,
    output logic                    cpu_stall,
    output logic [15:0]             slv_addr,
    output logic [7:0]              slv_data_w,
    output logic                    slv_do_write,
    input  logic [8*NUM_SLAVES-1:0] slv_data_r,
    input  logic [NUM_SLAVES-1:0]   slv_active,
    input  logic [INT_BITS-1:0]     irq_req,
    input  logic                    irq_ack,
    input  logic [2:0]              irq_ack_idx,
    output logic [INT_BITS-1:0]     irq_pending,
    output logic                    bootrom_enabled
);

    logic [7:0]          ie_q;
    logic [7:0]          ie_next;
    logic [INT_BITS-1:0] if_q;
    logic [INT_BITS-1:0] if_base;
    logic [INT_BITS-1:0] if_next;
    logic [INT_BITS-1:0] ack_mask;
    logic [7:0]          if_rd;
    logic [7:0]          slave_rd;
    logic [7:0]          dma_rd;
    logic                is_internal;
    logic                cpu_wr;
    logic                dma_busy;
    logic [15:0]         dma_addr;
    logic                dma_wr;
    logic [7:0]          dma_data;

    assign is_internal = (cpu_addr == ADDR_IE) || (cpu_addr == ADDR_IF) ||
                         (cpu_addr == ADDR_BOOT_OFF) || (cpu_addr == ADDR_DMA);

    // CPU register writes are ignored while DMA owns the bus.
    assign cpu_wr = cpu_do_write & ~dma_busy;

`ifdef GB_BUS_OAM_DMA_EN
    dma_state_t dma_state;
    logic [7:0] dma_src;

    gb_oam_dma u_dma (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (cpu_wr && (cpu_addr == ADDR_DMA)),
        .src_in  (cpu_data_w),
        .rd_data (slave_rd),
        .addr    (dma_addr),
        .wr      (dma_wr),
        .wr_data (dma_data),
        .src     (dma_src),
        .state   (dma_state)
    );

    assign dma_busy = (dma_state != IDLE);
    assign dma_rd   = dma_src;
`else
    assign dma_busy = 1'b0;
    assign dma_addr = 16'h0000;
    assign dma_wr   = 1'b0;
    assign dma_data = 8'h00;
    assign dma_rd   = 8'hFF;
`endif

    assign cpu_stall = dma_busy;

    // The DMA read address goes through the same echo remap as the CPU.
    assign slv_addr   = echo_remap(dma_busy ? dma_addr : cpu_addr, ECHO_MIRROR != 0);
    assign slv_data_w = dma_busy ? dma_data : cpu_data_w;
    assign slv_do_write = reset_n & (dma_busy ? dma_wr : (cpu_do_write & ~is_internal));

    // Scan from the top down so the lowest active index is the last writer.
    always_comb begin
        slave_rd = 8'hFF;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (slv_active[i])
                slave_rd = slv_data_r[8*i +: 8];
        end
    end

    always_comb begin
        if_rd                 = 8'hFF;
        if_rd[INT_BITS-1:0]   = if_q;
    end

    always_comb begin
        if (dma_busy)                       cpu_data_r = 8'hFF;
        else if (cpu_addr == ADDR_IE)       cpu_data_r = ie_q;
        else if (cpu_addr == ADDR_IF)       cpu_data_r = if_rd;
        else if (cpu_addr == ADDR_BOOT_OFF) cpu_data_r = 8'hFF;
        else if (cpu_addr == ADDR_DMA)      cpu_data_r = dma_rd;
        else                                cpu_data_r = slave_rd;
    end

    // Acknowledges beyond the implemented sources never match any bit.
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < INT_BITS; i++)
            ack_mask[i] = irq_ack && (irq_ack_idx == 3'(i));
    end

    // Requests are OR-ed in last so a set always beats a same-cycle clear.
    assign if_base = (cpu_wr && (cpu_addr == ADDR_IF)) ? cpu_data_w[INT_BITS-1:0] : if_q;
    assign if_next = (if_base & ~ack_mask) | irq_req;
    assign ie_next = (cpu_wr && (cpu_addr == ADDR_IE)) ? cpu_data_w : ie_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ie_q            <= 8'h00;
            if_q            <= '0;
            irq_pending     <= '0;
            bootrom_enabled <= 1'b1;
        end else begin
            ie_q        <= ie_next;
            if_q        <= if_next;
            irq_pending <= ie_next[INT_BITS-1:0] & if_next;
            if (cpu_wr && (cpu_addr == ADDR_BOOT_OFF) && (cpu_data_w != 8'h00))
                bootrom_enabled <= 1'b0;
        end
    end

endmodule
